// File: rtl/peripheral_stretch.sv
// Pulse-to-level stretcher: each accepted event becomes a HOLD_CYCLES-long high window,
// with excess events queued and replayed after a GAP_CYCLES low gap. Option: PERIPHERAL_STRETCH_RETRIGGER_EN.
module peripheral_stretch #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_MAX    = 3,
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES,
  localparam int CW   = $clog2(MAXC + 1),
  localparam int PW   = $clog2(PEND_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pulse,
  output logic          level,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [PW-1:0] r_pend, w_pend_next;
  logic          r_ovf, w_ovf_next;
  logic          r_level, r_busy;
  logic          w_enq, w_deq;
  logic          w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_enq        = 1'b0;
    w_deq        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (pulse) begin
          w_state_next = S_HOLD;
          w_cnt_next   = HOLD_LOAD;
        end
      end
      S_HOLD: begin
`ifdef PERIPHERAL_STRETCH_RETRIGGER_EN
        // A pulse inside the window extends it rather than queuing a replay.
        if (pulse) begin
          w_cnt_next = HOLD_LOAD;
        end else if (w_cnt_zero) begin
          w_state_next = S_GAP;
          w_cnt_next   = GAP_LOAD;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
`else
        w_enq = pulse;
        if (w_cnt_zero) begin
          w_state_next = S_GAP;
          w_cnt_next   = GAP_LOAD;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
`endif
      end
      S_GAP: begin
        if (!w_cnt_zero) begin
          w_cnt_next = r_cnt - 1'b1;
          w_enq      = pulse;
        end else if ((r_pend != '0) || pulse) begin
          // Oldest queued event wins; a simultaneous new pulse takes its slot in the queue.
          w_state_next = S_HOLD;
          w_cnt_next   = HOLD_LOAD;
          w_deq        = (r_pend != '0);
          w_enq        = pulse && (r_pend != '0);
        end else begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    w_pend_next = r_pend;
    w_ovf_next  = r_ovf;
    if (w_enq && !w_deq) begin
      if (r_pend == PEND_FULL) begin
        w_ovf_next = 1'b1;
      end else begin
        w_pend_next = r_pend + PW'(1);
      end
    end else if (w_deq && !w_enq) begin
      w_pend_next = r_pend - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
      r_level <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_pend  <= w_pend_next;
      r_ovf   <= w_ovf_next;
      r_level <= (w_state_next == S_HOLD);
      r_busy  <= (w_state_next != S_IDLE);
    end
  end

  assign level    = r_level;
  assign busy     = r_busy;
  assign pending  = r_pend;
  assign overflow = r_ovf;

endmodule
